// File: rtl/cpu_mem_pkg.sv
// Shared data-memory definitions: access-size encodings, the LSU state enum
// and a helper that maps an access size to its byte count.
package cpu_mem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_WAIT  = 2'd2,
    LSU_RESP  = 2'd3
  } lsu_state_e;

  // Byte count of an access; the unsigned variants share size[1:0] with the signed ones.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational size/alignment check for a data access; also used by the
// fetch unit.
module lsu_align_check
  import cpu_mem_pkg::*;
(
  input  logic       wr,
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic       illegal,
  output logic       misaligned
);

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (size)
      SIZE_B:  illegal = 1'b0;
      SIZE_BU: illegal = wr;
      SIZE_H:  misaligned = addr_lo[0];
      SIZE_HU: begin
        illegal    = wr;
        misaligned = addr_lo[0];
      end
      SIZE_W:  misaligned = |addr_lo;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, pre-checked, issued to memory,
// answered with a single-cycle response. Define LSU_MISALIGN_SPLIT_EN to run
// misaligned H/HU/W accesses as sequential byte accesses instead of faulting.
module load_store_unit
  import cpu_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exception,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_exception
);

  // Handshake: a request transfers on a rising CLK edge where req_valid and
  // req_ready are both high; responses are a one-cycle resp_valid pulse with no backpressure.
  lsu_state_e state;
  logic       r_wr;
  logic       r_exc;
  logic       exc_acc;
  logic       chk_illegal;
  logic       chk_misaligned;
  logic       pre_fail;
  logic       accept;

  lsu_align_check u_align_check (
    .wr        (req_wr),
    .size      (req_size),
    .addr_lo   (req_addr[1:0]),
    .illegal   (chk_illegal),
    .misaligned(chk_misaligned)
  );

  assign req_ready = RST_N && (state == LSU_IDLE);
  assign accept    = req_valid && req_ready;
  assign exc_acc   = r_exc | mem_exception;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        r_split;
  logic [2:0]  r_size;
  logic [31:0] r_wdata;
  logic [1:0]  byte_idx;
  logic [31:0] result;
  logic [31:0] assembled;
  logic [31:0] split_result;
  logic [31:0] next_wbyte;
  logic        last_byte;

  assign pre_fail   = chk_illegal;
  assign last_byte  = ({1'b0, byte_idx} == (size_bytes(r_size) - 3'd1));
  assign next_wbyte = {24'h0, r_wdata[{byte_idx + 2'd1, 3'b000} +: 8]};

  // Merge the byte arriving now into the partial result, then extend for H/HU.
  always_comb begin
    assembled = result;
    assembled[{byte_idx, 3'b000} +: 8] = mem_rdata[7:0];
    split_result = assembled;
    case (r_size)
      SIZE_H:  split_result = {{16{assembled[15]}}, assembled[15:0]};
      SIZE_HU: split_result = {16'h0, assembled[15:0]};
      default: split_result = assembled;
    endcase
  end
`else
  assign pre_fail = chk_illegal | chk_misaligned;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= LSU_IDLE;
      r_wr           <= 1'b0;
      r_exc          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_exception <= 1'b0;
      resp_rdata     <= 32'h0;
      mem_en         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= 32'h0;
      mem_size       <= 3'b000;
      mem_wdata      <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split        <= 1'b0;
      r_size         <= 3'b000;
      r_wdata        <= 32'h0;
      byte_idx       <= 2'd0;
      result         <= 32'h0;
`endif
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            r_wr  <= req_wr;
            r_exc <= 1'b0;
            if (pre_fail) begin
              resp_valid     <= 1'b1;
              resp_exception <= 1'b1;
              resp_rdata     <= 32'h0;
              state          <= LSU_RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_wr    <= req_wr;
              mem_addr  <= req_addr;
              mem_size  <= req_size;
              mem_wdata <= req_wdata;
              state     <= LSU_ISSUE;
`ifdef LSU_MISALIGN_SPLIT_EN
              r_split  <= chk_misaligned;
              r_size   <= req_size;
              r_wdata  <= req_wdata;
              byte_idx <= 2'd0;
              result   <= 32'h0;
              if (chk_misaligned) begin
                mem_size  <= req_wr ? SIZE_B : SIZE_BU;
                mem_wdata <= {24'h0, req_wdata[7:0]};
              end
`endif
            end
          end
        end
        LSU_ISSUE: begin
          r_exc  <= exc_acc;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          if (r_wr) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_split && !last_byte) begin
              mem_en    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_addr  <= mem_addr + 32'd1;
              mem_wdata <= next_wbyte;
              byte_idx  <= byte_idx + 2'd1;
            end else begin
              resp_valid     <= 1'b1;
              resp_exception <= exc_acc;
              resp_rdata     <= 32'h0;
              state          <= LSU_RESP;
            end
`else
            resp_valid     <= 1'b1;
            resp_exception <= exc_acc;
            resp_rdata     <= 32'h0;
            state          <= LSU_RESP;
`endif
          end else begin
            state <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (r_split && !last_byte) begin
            result   <= assembled;
            byte_idx <= byte_idx + 2'd1;
            mem_en   <= 1'b1;
            mem_addr <= mem_addr + 32'd1;
            state    <= LSU_ISSUE;
          end else begin
            resp_valid     <= 1'b1;
            resp_exception <= r_exc;
            resp_rdata     <= r_exc ? 32'h0 : (r_split ? split_result : mem_rdata);
            state          <= LSU_RESP;
          end
`else
          resp_valid     <= 1'b1;
          resp_exception <= r_exc;
          resp_rdata     <= r_exc ? 32'h0 : mem_rdata;
          state          <= LSU_RESP;
`endif
        end
        LSU_RESP: begin
          resp_valid     <= 1'b0;
          resp_exception <= 1'b0;
          resp_rdata     <= 32'h0;
          state          <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a little-endian byte memory model;
// split-mode expectations apply when LSU_MISALIGN_SPLIT_EN is defined.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exception;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [2:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_exception;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:4095];
  logic        init_mem = 1'b0;
  logic [31:0] en_addr_q[$];

  load_store_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exception(resp_exception),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_exception(mem_exception)
  );

  // ---------------- clock / memory model ----------------
  always #5 CLK = ~CLK;

  assign mem_exception = mem_en && (mem_addr == 32'h0000_0F00);

  function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [2:0] sz);
    logic [11:0] i;
    logic [7:0]  b0, b1, b2, b3;
    i  = a[11:0];
    b0 = mem[i];
    b1 = mem[i + 12'd1];
    b2 = mem[i + 12'd2];
    b3 = mem[i + 12'd3];
    case (sz)
      3'b000:  mem_load = {{24{b0[7]}}, b0};
      3'b100:  mem_load = {24'h0, b0};
      3'b001:  mem_load = {{16{b1[7]}}, b1, b0};
      3'b101:  mem_load = {16'h0, b1, b0};
      default: mem_load = {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'hBB; mem[12'h101] <= 8'hAA; mem[12'h102] <= 8'h99; mem[12'h103] <= 8'h88;
      mem[12'h104] <= 8'h44; mem[12'h105] <= 8'h33; mem[12'h106] <= 8'h22; mem[12'h107] <= 8'h11;
      mem[12'hF00] <= 8'h78; mem[12'hF01] <= 8'h56; mem[12'hF02] <= 8'h34; mem[12'hF03] <= 8'h12;
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[11:0]] <= mem_wdata[7:0];
      if (mem_size[1:0] != 2'b00) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
      if (mem_size[1:0] == 2'b10) begin
        mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
        mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
      end
    end
    if (mem_en && !mem_wr) mem_rdata <= mem_load(mem_addr, mem_size);
  end

  // ---------------- driver tasks ----------------
  task automatic preload();
    @(negedge CLK); init_mem = 1'b1;
    @(negedge CLK); init_mem = 1'b0;
  endtask

  // Issues one request and watches up to 40 cycles for the response; lat=-1 on timeout.
  task automatic run_req(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic rdy, output int lat,
                         output logic [31:0] rd, output logic ex, output int en_cnt,
                         output int wr_cnt);
    lat = -1; rd = 32'h0; ex = 1'b0; en_cnt = 0; wr_cnt = 0;
    en_addr_q.delete();
    @(negedge CLK);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
    rdy = req_ready;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (mem_en) begin
        en_cnt++;
        en_addr_q.push_back(mem_addr);
        if (mem_wr) wr_cnt++;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; ex = resp_exception;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({resp_valid, resp_exception, resp_rdata, mem_en, mem_wr, mem_addr, mem_size, mem_wdata} !== 103'd0) begin
      errors++; $display("FAIL reset_outputs: got nonzero output during reset, expected all 0");
    end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", req_ready); end
  endtask

  task automatic test_load_aligned();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    preload();
    run_req(1'b0, 3'b010, 32'h100, 32'h0, rdy, lat, rd, ex, en, wc);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL lw_ready: got %b expected 1", rdy); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata: got %h expected 8899aabb", rd); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL lw_exception: got %b expected 0", ex); end
    checks++; if (en !== 1) begin errors++; $display("FAIL lw_en_cycles: got %0d expected 1", en); end
    checks++;
    if (en_addr_q.size() < 1 || en_addr_q[0] !== 32'h100) begin
      errors++; $display("FAIL lw_mem_addr: got size %0d, expected one command at 00000100", en_addr_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  sz_t [3] = '{3'b000, 3'b100, 3'b101};
    logic [31:0] a_t  [3] = '{32'h101, 32'h101, 32'h102};
    logic [31:0] e_t  [3] = '{32'hFFFFFFAA, 32'h000000AA, 32'h00008899};
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      run_req(1'b0, sz_t[i], a_t[i], 32'h0, rdy, lat, rd, ex, en, wc);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 3", i, lat); end
      checks++; if (rd !== e_t[i]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, rd, e_t[i]); end
    end
  endtask

  task automatic test_store();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    run_req(1'b1, 3'b001, 32'h102, 32'h0000CAFE, rdy, lat, rd, ex, en, wc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sh_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sh_rdata: got %h expected 0", rd); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL sh_exception: got %b expected 0", ex); end
    checks++; if (wc !== 1) begin errors++; $display("FAIL sh_writes: got %0d expected 1", wc); end
    run_req(1'b0, 3'b010, 32'h100, 32'h0, rdy, lat, rd, ex, en, wc);
    checks++; if (rd !== 32'hCAFEAABB) begin errors++; $display("FAIL sh_readback: got %h expected cafeaabb", rd); end
  endtask

  task automatic test_misaligned();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    preload();
    run_req(1'b0, 3'b010, 32'h102, 32'h0, rdy, lat, rd, ex, en, wc);
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++; if (lat !== 9) begin errors++; $display("FAIL lw_split_latency: got %0d expected 9", lat); end
    checks++; if (rd !== 32'h33448899) begin errors++; $display("FAIL lw_split_rdata: got %h expected 33448899", rd); end
    checks++; if (ex !== 1'b0) begin errors++; $display("FAIL lw_split_exception: got %b expected 0", ex); end
    checks++; if (en !== 4) begin errors++; $display("FAIL lw_split_en_cycles: got %0d expected 4", en); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (en_addr_q.size() <= k || en_addr_q[k] !== 32'h102 + k) begin
        errors++; $display("FAIL lw_split_addr[%0d]: got queue size %0d, expected address %h", k, en_addr_q.size(), 32'h102 + k);
      end
    end
`else
    checks++; if (lat !== 1) begin errors++; $display("FAIL lw_mis_latency: got %0d expected 1", lat); end
    checks++; if (ex !== 1'b1) begin errors++; $display("FAIL lw_mis_exception: got %b expected 1", ex); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lw_mis_rdata: got %h expected 0", rd); end
    checks++; if (en !== 0) begin errors++; $display("FAIL lw_mis_en_cycles: got %0d expected 0", en); end
`endif
  endtask

  task automatic test_illegal();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    run_req(1'b0, 3'b011, 32'h100, 32'h0, rdy, lat, rd, ex, en, wc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL size011_latency: got %0d expected 1", lat); end
    checks++; if (ex !== 1'b1) begin errors++; $display("FAIL size011_exception: got %b expected 1", ex); end
    checks++; if (en !== 0) begin errors++; $display("FAIL size011_en_cycles: got %0d expected 0", en); end
    run_req(1'b1, 3'b100, 32'h104, 32'h00000055, rdy, lat, rd, ex, en, wc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sbu_latency: got %0d expected 1", lat); end
    checks++; if (ex !== 1'b1) begin errors++; $display("FAIL sbu_exception: got %b expected 1", ex); end
    checks++; if (wc !== 0) begin errors++; $display("FAIL sbu_writes: got %0d expected 0", wc); end
    checks++; if (mem[12'h104] !== 8'h44) begin errors++; $display("FAIL sbu_mem_byte: got %h expected 44", mem[12'h104]); end
  endtask

  task automatic test_mem_exception();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd;
    run_req(1'b0, 3'b010, 32'hF00, 32'h0, rdy, lat, rd, ex, en, wc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL memexc_latency: got %0d expected 3", lat); end
    checks++; if (ex !== 1'b1) begin errors++; $display("FAIL memexc_exception: got %b expected 1", ex); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL memexc_rdata: got %h expected 0", rd); end
  endtask

  task automatic test_reset_in_wait();
    logic rdy, ex; int lat, en, wc; logic [31:0] rd; int seen;
    @(negedge CLK);
    req_valid = 1'b1; req_wr = 1'b0; req_size = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_issue_en: got %b expected 1", mem_en); end
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_exception, resp_rdata, mem_en, mem_wr, mem_addr, mem_size, mem_wdata} !== 103'd0) begin
      errors++; $display("FAIL rst_wait_outputs: got nonzero output during reset, expected all 0");
    end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b expected 1", req_ready); end
    seen = 0;
    repeat (4) begin @(negedge CLK); if (resp_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_wait_no_resp: got %0d responses expected 0", seen); end
    run_req(1'b0, 3'b010, 32'h100, 32'h0, rdy, lat, rd, ex, en, wc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_after_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL rst_after_rdata: got %h expected 8899aabb", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_aligned();
    test_back_to_back();
    test_store();
    test_misaligned();
    test_illegal();
    test_mem_exception();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
